csr_trap_unit_mw: RTL and testbench
===================================

// Module: csr_trap_unit_mw
// PURPOSE
//  Memory/writeback-stage CSR file and trap sequencer; consumes MW-registered control (csr_reg_wr_MW,
//  csr_reg_rd_MW, is_mretMW, stall_MW) from the controller pipeline register. Holds machine-mode
//  CSRs, takes timer/external interrupts at instruction retirement, executes mret, and drives a
//  registered PC redirect (epc_taken/epc) back to fetch.
// PARAMETERS
//  XLEN         32      datapath/CSR width
//  MTVEC_RESET  32'h0   reset value of mtvec
// PORTS
//  clk              in   1     single clock, rising edge
//  reset            in   1     asynchronous, active-low reset
//  stall_MW         in   1     MW stage stalled; instruction in MW does not retire
//  instr_valid_MW   in   1     a real (non-bubble) instruction occupies MW
//  csr_reg_wr_MW    in   1     CSR write request
//  csr_reg_rd_MW    in   1     CSR read request
//  is_mretMW        in   1     instruction in MW is mret
//  csr_addr_MW      in   12    CSR address
//  csr_wdata_MW     in   XLEN  CSR write data
//  pc_next_MW       in   XLEN  architectural next PC of instruction in MW
//  timer_intr       in   1     timer interrupt level
//  ext_intr         in   1     external interrupt level
//  csr_rdata        out  XLEN  CSR read data (combinational)
//  epc_taken        out  1     one-cycle redirect pulse (registered)
//  epc              out  XLEN  redirect target, valid while epc_taken=1 (registered)
// BEHAVIOUR
//  - CSRs: mstatus 0x300 (MIE b3, MPIE b7; others read 0), mie 0x304 (MTIE b7, MEIE b11),
//    mtvec 0x305 (full word; [1:0]=01 vectored, else direct), mepc 0x341 ([1:0] forced 0),
//    mcause 0x342, mip 0x344 (read-only MTIP b7, MEIP b11). Unmapped: read 0, write ignored.
//  - Reset: all CSRs 0 except mtvec=MTIE_RESET... i.e. MTVEC_RESET; mip=0; epc_taken=0; epc=0; state RUN.
//  - mip registered each cycle from timer_intr/ext_intr (1-cycle latency into mip).
//  - retire = instr_valid_MW & !stall_MW & state==RUN. No write/trap/mret without retire.
//  - csr_rdata = mapped value when csr_reg_rd_MW else 0; reflects pre-write value same cycle.
//  - FSM: RUN -> TRAP on retire & mstatus.MIE & (mip&mie)!=0 & !is_mretMW;
//         RUN -> MRET on retire & is_mretMW; TRAP/MRET -> RUN unconditionally after 1 cycle.
//  - In TRAP/MRET cycle: epc_taken=1; instr_valid_MW ignored (upstream squashes); stall_MW
//    does not extend the state.
//  - Trap entry (edge leaving RUN): mepc<=pc_next_MW; MPIE<=MIE; MIE<=0;
//    mcause<=0x8000000B (ext, priority) or 0x80000007 (timer);
//    epc<=mtvec base ({mtvec[31:2],2'b0}) + (vectored ? 4*cause_code : 0), 32-bit wrap.
//  - mret (edge leaving RUN): MIE<=MPIE; MPIE<=1; epc<=mepc.
//  - Same-cycle CSR write + trap: CSR write commits, then trap updates override mstatus/mepc/
//    mcause; enable check uses pre-write mstatus/mie.
//  - Same-cycle mret + pending interrupt: mret wins; interrupt re-evaluated after return to RUN.
//  - Reset asserted mid TRAP/MRET: outputs drop to reset values immediately, no redirect.
// CONFIGURATION
//  CSR_COUNTERS_EN defined: mcycle 0xB00 / mcycleh 0xB80 (64-bit, +1 every cycle) and
//   minstret 0xB02 / minstreth 0xB82 (+1 per retire); writable, write beats increment same cycle;
//   reset 0. Undefined: those addresses read 0, writes ignored, no counter flops.
// TESTING
//  T1 mtvec=0x100, mie=0x80, mstatus=0x8; timer_intr=1, retire pc_next=0x40 -> next cycle
//     epc_taken=1, epc=0x100; mepc=0x40, mcause=0x80000007, mstatus=0x80.
//  T2 mtvec=0x101, mie=0x880, MIE=1, timer+ext both high -> epc=0x12C, mcause=0x8000000B.
//  T3 after T1, retire mret -> epc_taken=1, epc=0x40, mstatus=0x88; pulse exactly 1 cycle.
//  T4 pending enabled interrupt with stall_MW=1 for 5 cycles -> epc_taken=0 throughout;
//     trap 1 cycle after stall_MW falls with retire.
//  T5 csr write mstatus=0x0 coincident with enabled interrupt -> trap taken, mstatus=0x80.
//  T6 reset low during TRAP cycle -> epc_taken=0, epc=0, all CSRs reset; with CSR_COUNTERS_EN,
//     read 0xB00 after 10 post-reset cycles returns 10.

Source files
------------

// File: rtl/csr_trap_unit_mw_if.sv
// Memory/writeback-stage bundle between the controller pipeline register and csr_trap_unit_mw.
// The master drives the MW-registered control; the slave returns read data and the PC redirect.
interface csr_trap_unit_mw_if #(
  parameter int XLEN = 32
);
  logic            stall_MW;
  logic            instr_valid_MW;
  logic            csr_reg_wr_MW;
  logic            csr_reg_rd_MW;
  logic            is_mretMW;
  logic [11:0]     csr_addr_MW;
  logic [XLEN-1:0] csr_wdata_MW;
  logic [XLEN-1:0] pc_next_MW;
  logic [XLEN-1:0] csr_rdata;
  logic            epc_taken;
  logic [XLEN-1:0] epc;

  modport master (
    output stall_MW, instr_valid_MW, csr_reg_wr_MW, csr_reg_rd_MW, is_mretMW,
           csr_addr_MW, csr_wdata_MW, pc_next_MW,
    input  csr_rdata, epc_taken, epc
  );

  modport slave (
    input  stall_MW, instr_valid_MW, csr_reg_wr_MW, csr_reg_rd_MW, is_mretMW,
           csr_addr_MW, csr_wdata_MW, pc_next_MW,
    output csr_rdata, epc_taken, epc
  );
endinterface

// File: rtl/csr_trap_unit_mw.sv
// Machine-mode CSR file and trap/mret sequencer at MW retirement, with a registered PC redirect.
// Optional 64-bit mcycle/minstret counters are built only when CSR_COUNTERS_EN is defined.
module csr_trap_unit_mw #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 timer_intr,
  input  logic                 ext_intr,
  csr_trap_unit_mw_if.slave    mw
);

  typedef enum logic [1:0] {ST_RUN, ST_TRAP, ST_MRET} state_e;

  state_e          state_q, state_d;
  logic            mstatus_mie_q, mstatus_mie_d;
  logic            mstatus_mpie_q, mstatus_mpie_d;
  logic            mie_mtie_q, mie_mtie_d;
  logic            mie_meie_q, mie_meie_d;
  logic            mip_mtip_q, mip_mtip_d;
  logic            mip_meip_q, mip_meip_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic            epc_taken_q, epc_taken_d;
  logic [XLEN-1:0] epc_q, epc_d;
`ifdef CSR_COUNTERS_EN
  logic [2*XLEN-1:0] mcycle_q, mcycle_d;
  logic [2*XLEN-1:0] minstret_q, minstret_d;
`endif

  logic            retire;
  logic            irq_ext, irq_tmr;
  logic            take_trap, take_mret;
  logic [4:0]      cause_code;
  logic [XLEN-1:0] trap_target;
  logic [XLEN-1:0] rdata;

  assign retire     = mw.instr_valid_MW & ~mw.stall_MW & (state_q == ST_RUN);
  assign irq_ext    = mip_meip_q & mie_meie_q;
  assign irq_tmr    = mip_mtip_q & mie_mtie_q;
  assign take_mret  = retire & mw.is_mretMW;
  assign take_trap  = retire & ~mw.is_mretMW & mstatus_mie_q & (irq_ext | irq_tmr);
  assign cause_code = irq_ext ? 5'd11 : 5'd7;
  // Vectored mode offsets the base by 4*cause; the sum wraps at XLEN bits.
  assign trap_target = (mtvec_q & ~XLEN'(3))
                     + ((mtvec_q[1:0] == 2'b01) ? XLEN'({cause_code, 2'b00}) : '0);

  // Read path reflects the pre-write state of the current cycle.
  always_comb begin
    rdata = '0;
    if (mw.csr_reg_rd_MW) begin
      case (mw.csr_addr_MW)
        12'h300: rdata = XLEN'({mstatus_mpie_q, 3'b000, mstatus_mie_q, 3'b000});
        12'h304: rdata = XLEN'({mie_meie_q, 3'b000, mie_mtie_q, 7'b0000000});
        12'h305: rdata = mtvec_q;
        12'h341: rdata = mepc_q;
        12'h342: rdata = mcause_q;
        12'h344: rdata = XLEN'({mip_meip_q, 3'b000, mip_mtip_q, 7'b0000000});
`ifdef CSR_COUNTERS_EN
        12'hB00: rdata = mcycle_q[XLEN-1:0];
        12'hB80: rdata = mcycle_q[2*XLEN-1:XLEN];
        12'hB02: rdata = minstret_q[XLEN-1:0];
        12'hB82: rdata = minstret_q[2*XLEN-1:XLEN];
`endif
        default: rdata = '0;
      endcase
    end
  end

  assign mw.csr_rdata = rdata;
  assign mw.epc_taken = epc_taken_q;
  assign mw.epc       = epc_q;

  // NOTE: every _d gets its hold value first so no path through this block can infer a latch.
  always_comb begin
    state_d        = state_q;
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_mtie_d     = mie_mtie_q;
    mie_meie_d     = mie_meie_q;
    mip_mtip_d     = timer_intr;
    mip_meip_d     = ext_intr;
    mtvec_d        = mtvec_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    epc_taken_d    = take_trap | take_mret;
    epc_d          = epc_q;
`ifdef CSR_COUNTERS_EN
    mcycle_d       = mcycle_q + 1'b1;
    minstret_d     = minstret_q + {{(2*XLEN-1){1'b0}}, retire};
`endif

    if (retire && mw.csr_reg_wr_MW) begin
      case (mw.csr_addr_MW)
        12'h300: begin
          mstatus_mie_d  = mw.csr_wdata_MW[3];
          mstatus_mpie_d = mw.csr_wdata_MW[7];
        end
        12'h304: begin
          mie_mtie_d = mw.csr_wdata_MW[7];
          mie_meie_d = mw.csr_wdata_MW[11];
        end
        12'h305: mtvec_d  = mw.csr_wdata_MW;
        12'h341: mepc_d   = mw.csr_wdata_MW & ~XLEN'(3);
        12'h342: mcause_d = mw.csr_wdata_MW;
`ifdef CSR_COUNTERS_EN
        12'hB00: mcycle_d[XLEN-1:0]        = mw.csr_wdata_MW;
        12'hB80: mcycle_d[2*XLEN-1:XLEN]   = mw.csr_wdata_MW;
        12'hB02: minstret_d[XLEN-1:0]      = mw.csr_wdata_MW;
        12'hB82: minstret_d[2*XLEN-1:XLEN] = mw.csr_wdata_MW;
`endif
        default: ;
      endcase
    end

    // Trap and mret updates land after the CSR write and use only pre-write state.
    if (take_mret) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
      epc_d          = mepc_q;
    end else if (take_trap) begin
      mepc_d         = mw.pc_next_MW & ~XLEN'(3);
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
      mcause_d       = {1'b1, {(XLEN-6){1'b0}}, cause_code};
      epc_d          = trap_target;
    end

    case (state_q)
      ST_RUN: begin
        if (take_mret)      state_d = ST_MRET;
        else if (take_trap) state_d = ST_TRAP;
      end
      ST_TRAP, ST_MRET: state_d = ST_RUN;
      default:          state_d = ST_RUN;
    endcase
  end

  // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_RUN;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_mtie_q     <= 1'b0;
      mie_meie_q     <= 1'b0;
      mip_mtip_q     <= 1'b0;
      mip_meip_q     <= 1'b0;
      mtvec_q        <= MTVEC_RESET;
      mepc_q         <= '0;
      mcause_q       <= '0;
      epc_taken_q    <= 1'b0;
      epc_q          <= '0;
`ifdef CSR_COUNTERS_EN
      mcycle_q       <= '0;
      minstret_q     <= '0;
`endif
    end else begin
      state_q        <= state_d;
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_mtie_q     <= mie_mtie_d;
      mie_meie_q     <= mie_meie_d;
      mip_mtip_q     <= mip_mtip_d;
      mip_meip_q     <= mip_meip_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      epc_taken_q    <= epc_taken_d;
      epc_q          <= epc_d;
`ifdef CSR_COUNTERS_EN
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
`endif
    end
  end

endmodule

// File: tb/tb_csr_trap_unit_mw.sv
// Self-checking bench for csr_trap_unit_mw: directed trap/mret scenarios with literal expectations,
// then randomized traffic compared every cycle against an architectural model of the CSR file.
module tb_csr_trap_unit_mw;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic timer_intr = 1'b0;
  logic ext_intr = 1'b0;

  csr_trap_unit_mw_if #(.XLEN(32)) mwif ();

  csr_trap_unit_mw #(.XLEN(32), .MTVEC_RESET(32'h0)) dut (
    .clk        (clk),
    .reset      (reset),
    .timer_intr (timer_intr),
    .ext_intr   (ext_intr),
    .mw         (mwif)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Architectural model state.
  bit          m_mie, m_mpie, m_mtie, m_meie, m_mtip, m_meip, m_taken;
  logic [31:0] m_mtvec, m_mepc, m_mcause, m_epc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'(m_mie) * 8 + 32'(m_mpie) * 128;
      12'h304: return 32'(m_mtie) * 128 + 32'(m_meie) * 2048;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return 32'(m_mtip) * 128 + 32'(m_meip) * 2048;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_mtie = 0; m_meie = 0; m_mtip = 0; m_meip = 0; m_taken = 0;
    m_mtvec = 32'h0; m_mepc = 32'h0; m_mcause = 32'h0; m_epc = 32'h0;
  endtask

  // One clock of architectural behaviour for the inputs presented this cycle.
  task automatic model_step(input bit v, input bit st, input bit wr, input bit mr,
                            input logic [11:0] a, input logic [31:0] wd, input logic [31:0] pc);
    bit          retire, old_mie, old_mpie, pend_e, pend_t, trap, do_mret;
    logic [31:0] old_mtvec, old_mepc, code;
    retire    = v && !st && !m_taken;
    old_mie   = m_mie;
    old_mpie  = m_mpie;
    old_mtvec = m_mtvec;
    old_mepc  = m_mepc;
    pend_e    = m_meip && m_meie;
    pend_t    = m_mtip && m_mtie;
    if (retire && wr) begin
      case (a)
        12'h300: begin m_mie = wd[3]; m_mpie = wd[7]; end
        12'h304: begin m_mtie = wd[7]; m_meie = wd[11]; end
        12'h305: m_mtvec = wd;
        12'h341: m_mepc = wd - (wd % 4);
        12'h342: m_mcause = wd;
        default: ;
      endcase
    end
    do_mret = retire && mr;
    trap    = retire && !mr && old_mie && (pend_e || pend_t);
    m_taken = do_mret || trap;
    if (do_mret) begin
      m_mie  = old_mpie;
      m_mpie = 1;
      m_epc  = old_mepc;
    end else if (trap) begin
      code     = pend_e ? 32'd11 : 32'd7;
      m_mepc   = pc - (pc % 4);
      m_mpie   = old_mie;
      m_mie    = 0;
      m_mcause = 32'h8000_0000 + code;
      m_epc    = (old_mtvec - (old_mtvec % 4)) + ((old_mtvec % 4 == 1) ? 4 * code : 32'd0);
    end
    m_mtip = timer_intr;
    m_meip = ext_intr;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input bit v, input bit st, input bit wr, input bit rd, input bit mr,
                       input logic [11:0] a, input logic [31:0] wd, input logic [31:0] pc,
                       output logic [31:0] obs);
    mwif.instr_valid_MW = v;
    mwif.stall_MW       = st;
    mwif.csr_reg_wr_MW  = wr;
    mwif.csr_reg_rd_MW  = rd;
    mwif.is_mretMW      = mr;
    mwif.csr_addr_MW    = a;
    mwif.csr_wdata_MW   = wd;
    mwif.pc_next_MW     = pc;
    #1;
    obs = mwif.csr_rdata;
    check("csr_rdata", obs, rd ? model_read(a) : 32'h0);
    model_step(v, st, wr, mr, a, wd, pc);
    @(posedge clk);
    #1;
    check("epc_taken", 32'(mwif.epc_taken), 32'(m_taken));
    if (m_taken) check("epc", mwif.epc, m_epc);
    @(negedge clk);
  endtask

  logic [31:0] scratch;

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 12'h0, 32'h0, 32'h0, scratch);
  endtask

  task automatic wr_csr(input logic [11:0] a, input logic [31:0] d);
    cycle(1, 0, 1, 0, 0, a, d, 32'h0, scratch);
  endtask

  task automatic rd_csr(input logic [11:0] a, output logic [31:0] d);
    cycle(0, 0, 0, 1, 0, a, 32'h0, 32'h0, d);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    timer_intr = 1'b0;
    ext_intr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  logic [11:0] addr_tbl [8] = '{12'h300, 12'h304, 12'h305, 12'h341,
                                12'h342, 12'h344, 12'h7C0, 12'h300};
  logic [31:0] useful_tbl [6] = '{32'h8, 32'h88, 32'h80, 32'h880, 32'h800, 32'h101};

  initial begin
    logic [31:0] v;
    mwif.instr_valid_MW = 0; mwif.stall_MW = 0; mwif.csr_reg_wr_MW = 0;
    mwif.csr_reg_rd_MW = 0; mwif.is_mretMW = 0; mwif.csr_addr_MW = '0;
    mwif.csr_wdata_MW = '0; mwif.pc_next_MW = '0;
    @(negedge clk);
    do_reset();

    // Reset state.
    check("rst_epc_taken", 32'(mwif.epc_taken), 32'h0);
    check("rst_epc", mwif.epc, 32'h0);
    rd_csr(12'h305, v); check("rst_mtvec", v, 32'h0);
    rd_csr(12'h300, v); check("rst_mstatus", v, 32'h0);

    // T1: direct-mode timer trap.
    wr_csr(12'h305, 32'h100); wr_csr(12'h304, 32'h80); wr_csr(12'h300, 32'h8);
    timer_intr = 1; idle();
    cycle(1, 0, 0, 0, 0, 12'h0, 32'h0, 32'h40, scratch);
    check("T1_taken", 32'(mwif.epc_taken), 32'h1);
    check("T1_epc", mwif.epc, 32'h100);
    idle();
    rd_csr(12'h341, v); check("T1_mepc", v, 32'h40);
    rd_csr(12'h342, v); check("T1_mcause", v, 32'h8000_0007);
    rd_csr(12'h300, v); check("T1_mstatus", v, 32'h80);

    // T3: mret back to mepc, single-cycle pulse.
    cycle(1, 0, 0, 0, 1, 12'h0, 32'h0, 32'h0, scratch);
    check("T3_taken", 32'(mwif.epc_taken), 32'h1);
    check("T3_epc", mwif.epc, 32'h40);
    idle();
    check("T3_pulse", 32'(mwif.epc_taken), 32'h0);
    rd_csr(12'h300, v); check("T3_mstatus", v, 32'h88);
    timer_intr = 0; idle(); idle();

    // T2: vectored mode, external wins over timer.
    do_reset();
    wr_csr(12'h305, 32'h101); wr_csr(12'h304, 32'h880); wr_csr(12'h300, 32'h8);
    timer_intr = 1; ext_intr = 1; idle();
    cycle(1, 0, 0, 0, 0, 12'h0, 32'h0, 32'h200, scratch);
    check("T2_epc", mwif.epc, 32'h12C);
    idle();
    rd_csr(12'h342, v); check("T2_mcause", v, 32'h8000_000B);

    // T4: stall holds off the trap until retirement.
    do_reset();
    wr_csr(12'h305, 32'h100); wr_csr(12'h304, 32'h80); wr_csr(12'h300, 32'h8);
    timer_intr = 1; idle();
    for (int i = 0; i < 5; i++) begin
      cycle(1, 1, 0, 0, 0, 12'h0, 32'h0, 32'h80, scratch);
      check("T4_stalled", 32'(mwif.epc_taken), 32'h0);
    end
    cycle(1, 0, 0, 0, 0, 12'h0, 32'h0, 32'h80, scratch);
    check("T4_taken", 32'(mwif.epc_taken), 32'h1);
    idle();

    // T5: mstatus write coincident with a trap; enable uses the pre-write MIE.
    do_reset();
    wr_csr(12'h304, 32'h80); wr_csr(12'h300, 32'h8);
    timer_intr = 1; idle();
    cycle(1, 0, 1, 0, 0, 12'h300, 32'h0, 32'h60, scratch);
    check("T5_taken", 32'(mwif.epc_taken), 32'h1);
    idle();
    rd_csr(12'h300, v); check("T5_mstatus", v, 32'h80);

    // T6: asynchronous reset during the TRAP cycle.
    do_reset();
    wr_csr(12'h305, 32'h100); wr_csr(12'h304, 32'h80); wr_csr(12'h300, 32'h8);
    timer_intr = 1; idle();
    cycle(1, 0, 0, 0, 0, 12'h0, 32'h0, 32'h44, scratch);
    reset = 1'b0;
    #1;
    check("T6_taken", 32'(mwif.epc_taken), 32'h0);
    check("T6_epc", mwif.epc, 32'h0);
    do_reset();
    rd_csr(12'h341, v); check("T6_mepc", v, 32'h0);
    rd_csr(12'h305, v); check("T6_mtvec", v, 32'h0);
`ifdef CSR_COUNTERS_EN
    do_reset();
    repeat (10) idle();
    rd_csr(12'hB00, v); check("T6_mcycle", v, 32'd10);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] wd;
      if ($urandom_range(9) == 0) timer_intr = ~timer_intr;
      if ($urandom_range(11) == 0) ext_intr = ~ext_intr;
      wd = ($urandom_range(1) == 0) ? useful_tbl[$urandom_range(5)] : $urandom;
      cycle($urandom_range(3) != 0, $urandom_range(3) == 0, $urandom_range(2) == 0,
            $urandom_range(1) == 0, $urandom_range(11) == 0,
            addr_tbl[$urandom_range(7)], wd, $urandom, scratch);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
